pmem_arbiter: RTL and testbench

//  Shares the single physical-memory (cacheline) port between the I-cache (IF stage) and the D-cache (MEM stage) miss paths.

---
 rtl/pmem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_pmem_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Arbitrates the single cacheline memory port between the I-cache and D-cache miss paths.
// The D side has fixed priority; a saturating starvation counter guarantees instruction fetch progress.

module pmem_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic d_pmem_read,
  input logic d_pmem_write
);

  // A D-cache read and writeback requested together is a protocol error upstream
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write));

endmodule

module pmem_arbiter #(
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LINE_W-1:0] wdata_r;
  logic              op_wr_r;
  logic [3:0]        starve_cnt_r;
  logic              pmem_read_r;
  logic              pmem_write_r;
  logic              d_req_s;
  logic              grant_i_s;
  logic              grant_d_s;
  logic              done_s;

  // Arbitration is only evaluated in IDLE; D wins unless the I read has been starved
  always_comb begin
    d_req_s   = d_pmem_read | d_pmem_write;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (d_req_s && (starve_cnt_r < STARVE_MAX)) begin
        grant_d_s = 1'b1;
      end else if (i_pmem_read) begin
        grant_i_s = 1'b1;
      end else if (d_req_s) begin
        grant_d_s = 1'b1;
      end else begin
        grant_d_s = 1'b0;
      end
    end else begin
      grant_i_s = 1'b0;
    end
  end

  assign done_s = pmem_resp & ((state_r == ST_SERVE_I) | (state_r == ST_SERVE_D));

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_d_s) begin
          state_nxt_s = ST_SERVE_D;
        end else if (grant_i_s) begin
          state_nxt_s = ST_SERVE_I;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (pmem_resp) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RELEASE: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // State, transaction latches and registered adaptor request strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      wdata_r      <= '0;
      op_wr_r      <= 1'b0;
      pmem_read_r  <= 1'b0;
      pmem_write_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_d_s) begin
        addr_r       <= d_pmem_address;
        wdata_r      <= d_pmem_wdata;
        op_wr_r      <= d_pmem_write;
        pmem_read_r  <= ~d_pmem_write;
        pmem_write_r <= d_pmem_write;
      end else if (grant_i_s) begin
        addr_r       <= i_pmem_address;
        op_wr_r      <= 1'b0;
        pmem_read_r  <= 1'b1;
        pmem_write_r <= 1'b0;
      end else if (done_s) begin
        pmem_read_r  <= 1'b0;
        pmem_write_r <= 1'b0;
      end else begin
        pmem_read_r  <= pmem_read_r;
        pmem_write_r <= pmem_write_r;
      end
    end
  end

  // Starvation counter: counts D grants that bypassed a waiting I read
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_d_s && i_pmem_read) begin
      if (starve_cnt_r < STARVE_MAX) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else if (grant_i_s) begin
      starve_cnt_r <= 4'd0;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign pmem_read    = pmem_read_r;
  assign pmem_write   = pmem_write_r;
  assign pmem_address = addr_r;
  assign pmem_wdata   = wdata_r;

  // Completion is forwarded in the same cycle; read data is broadcast and qualified by resp only
  assign i_pmem_resp  = pmem_resp & (state_r == ST_SERVE_I);
  assign d_pmem_resp  = pmem_resp & (state_r == ST_SERVE_D);
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  pmem_arbiter_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .d_pmem_read  (d_pmem_read),
    .d_pmem_write (d_pmem_write)
  );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized bench for pmem_arbiter: caches and adaptor are modelled as simple agents and every
// cycle the outputs are compared with a transaction-level model of the arbitration rules.

module tb_pmem_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: who owns the port, whether a turnaround gap is pending, and latched transaction
  int                m_owner;   // 0 none, 1 I-cache, 2 D-cache
  int                m_gap;     // idle cycles still to elapse before arbitration is allowed
  int                m_starve;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  bit                m_wr;

  // Agent state
  bit i_pend, d_pend, d_is_wr;
  int adp_wait;

  task automatic model_reset();
    m_owner = 0; m_gap = 0; m_starve = 0;
    m_addr = '0; m_wdata = '0; m_wr = 1'b0;
    adp_wait = 0;
  endtask

  task automatic run_phase(input int ncyc, input int p_i, input int p_d, input int p_rst);
    bit exp_i_resp, exp_d_resp, d_req;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (!i_pend && ($urandom_range(99) < p_i)) i_pend = 1'b1;
      if (!d_pend && ($urandom_range(99) < p_d)) begin
        d_pend  = 1'b1;
        d_is_wr = 1'($urandom_range(1));
      end
      i_pmem_read    = i_pend;
      d_pmem_read    = d_pend && !d_is_wr;
      d_pmem_write   = d_pend && d_is_wr;
      i_pmem_address = $urandom;
      d_pmem_address = $urandom;
      d_pmem_wdata   = rand_line();
      pmem_rdata     = rand_line();
      if (m_owner != 0) begin
        if (adp_wait == 0) pmem_resp = 1'b1;
        else begin
          pmem_resp = 1'b0;
          adp_wait--;
        end
      end else begin
        pmem_resp = ($urandom_range(99) < 15);
      end
      rst = ($urandom_range(999) < p_rst);
      #1;
      exp_i_resp = (m_owner == 1) && pmem_resp;
      exp_d_resp = (m_owner == 2) && pmem_resp;
      check_val("pmem_read",    LINE_W'(pmem_read),    LINE_W'((m_owner == 1) || (m_owner == 2 && !m_wr)));
      check_val("pmem_write",   LINE_W'(pmem_write),   LINE_W'((m_owner == 2) && m_wr));
      check_val("pmem_address", LINE_W'(pmem_address), LINE_W'(m_addr));
      check_val("pmem_wdata",   pmem_wdata,            m_wdata);
      check_val("i_pmem_resp",  LINE_W'(i_pmem_resp),  LINE_W'(exp_i_resp));
      check_val("d_pmem_resp",  LINE_W'(d_pmem_resp),  LINE_W'(exp_d_resp));
      check_val("i_pmem_rdata", i_pmem_rdata,          pmem_rdata);
      check_val("d_pmem_rdata", d_pmem_rdata,          pmem_rdata);
      if (exp_i_resp) i_pend = 1'b0;
      if (exp_d_resp) d_pend = 1'b0;
      d_req = d_pmem_read || d_pmem_write;
      if (rst) begin
        model_reset();
      end else if (m_owner != 0) begin
        if (pmem_resp) begin
          m_owner = 0;
          m_gap   = 1;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if ((d_req && m_starve < LIMIT) || (d_req && !i_pmem_read)) begin
        m_owner = 2;
        m_addr  = d_pmem_address;
        m_wdata = d_pmem_wdata;
        m_wr    = d_pmem_write;
        if (i_pmem_read && m_starve < LIMIT) m_starve++;
        adp_wait = $urandom_range(1, 4);
      end else if (i_pmem_read) begin
        m_owner  = 1;
        m_addr   = i_pmem_address;
        m_wr     = 1'b0;
        m_starve = 0;
        adp_wait = $urandom_range(1, 4);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; d_is_wr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_pmem_read",  LINE_W'(pmem_read),  '0);
    check_val("reset_pmem_write", LINE_W'(pmem_write), '0);
    check_val("reset_i_resp",     LINE_W'(i_pmem_resp), '0);
    check_val("reset_d_resp",     LINE_W'(d_pmem_resp), '0);
    // mixed traffic with occasional resets, then saturation pressure, then sparse traffic
    run_phase(1500, 30, 30, 5);
    run_phase(1500, 100, 100, 0);
    run_phase(1000, 10, 10, 20);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
